// File: rtl/flowing_water_lights.sv
`default_nettype none
// ============================================================================
// Module      : flowing_water_lights
// Description : Eight-LED chaser. A single lit LED rotates left across
//               led[7:0] at a rate picked by freq_set. A debounced push-button
//               toggles between running and paused, and the chaser resumes
//               from the paused position.
// Revision    : 1.0  initial release
// ============================================================================
module flowing_water_lights #(
  parameter int unsigned DIV_00 = 16,  // cycles per step, freq_set = 2'b00
  parameter int unsigned DIV_01 = 8,   // cycles per step, freq_set = 2'b01
  parameter int unsigned DIV_10 = 4,   // cycles per step, freq_set = 2'b10
  parameter int unsigned DIV_11 = 2,   // cycles per step, freq_set = 2'b11
  parameter int unsigned CNT_W  = 24   // prescaler width, holds max(DIV)-1
) (
  input  logic       clk,
  input  logic       rst,       // asynchronous, active-low
  input  logic       button,    // debounced, asynchronous to clk
  input  logic [1:0] freq_set,  // quasi-static rate select
  output logic [7:0] led
);

  // Terminal counts: a tick fires once the prescaler reaches DIV-1.
  localparam logic [CNT_W-1:0] C_LAST_00 = CNT_W'(DIV_00 - 1);
  localparam logic [CNT_W-1:0] C_LAST_01 = CNT_W'(DIV_01 - 1);
  localparam logic [CNT_W-1:0] C_LAST_10 = CNT_W'(DIV_10 - 1);
  localparam logic [CNT_W-1:0] C_LAST_11 = CNT_W'(DIV_11 - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

  run_state_t       state;
  run_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       led_next;
  logic [CNT_W-1:0] last;
  logic             b_s1;
  logic             b_s2;
  logic             b_d;
  logic [1:0]       fs_q;
  logic             press;
  logic             fs_change;
  logic             tick;

  // Button synchroniser, edge-detect history and freq_set capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
      b_d  <= 1'b0;
      fs_q <= 2'b00;
    end else begin
      b_s1 <= button;
      b_s2 <= b_s1;
      b_d  <= b_s2;
      fs_q <= freq_set;
    end
  end

  assign press     = b_s2 & ~b_d;
  assign fs_change = (freq_set != fs_q);

  // Terminal count for the currently selected rate.
  always_comb begin
    last = C_LAST_00;
    case (freq_set)
      2'b00:   last = C_LAST_00;
      2'b01:   last = C_LAST_01;
      2'b10:   last = C_LAST_10;
      2'b11:   last = C_LAST_11;
      default: last = C_LAST_00;
    endcase
  end

  // >= rather than == so that switching to a faster rate can never overrun.
  assign tick = (state == ST_RUNNING) && !fs_change && (cnt >= last);

  // Run/pause state register plus prescaler and LED registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_PAUSED;
      cnt   <= '0;
      led   <= 8'h00;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      led   <= led_next;
    end
  end

  // Next-state logic: a press always wins over a rate change or a tick.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    led_next   = led;
    case (state)
      ST_PAUSED: begin
        if (press) begin
          state_next = ST_RUNNING;
          cnt_next   = '0;
          // Only the very first start lights an LED; later starts resume.
          if (led == 8'h00) begin
            led_next = 8'h01;
          end
        end
      end
      ST_RUNNING: begin
        if (press) begin
          state_next = ST_PAUSED;
          // Prescaler freezes while paused; a coincident tick still clears it.
          if (tick) begin
            cnt_next = '0;
          end
        end else if (fs_change) begin
          cnt_next = '0;
        end else if (tick) begin
          cnt_next = '0;
          led_next = {led[6:0], led[7]};
        end else begin
          cnt_next = cnt + C_CNT_ONE;
        end
      end
      default: begin
        state_next = ST_PAUSED;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_flowing_water_lights.sv
`default_nettype none
// ============================================================================
// Module      : tb_flowing_water_lights
// Description : Self-checking bench for flowing_water_lights. A behavioural
//               model tracks the lit LED position and the elapsed time in the
//               current step period and is compared against led every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_flowing_water_lights;

  logic       clk;
  logic       rst;
  logic       button;
  logic [1:0] freq_set;
  logic [7:0] led;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit       m_running;
  int       m_pos;       // -1 = all dark, else index of the lit LED
  int       m_elapsed;   // cycles spent in the current step period
  bit [2:0] m_hist;      // button samples at the last three edges, [0] newest
  bit [1:0] m_fs_prev;

  flowing_water_lights #(
    .DIV_00(16),
    .DIV_01(8),
    .DIV_10(4),
    .DIV_11(2),
    .CNT_W (24)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .button  (button),
    .freq_set(freq_set),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_led();
    if (m_pos < 0) return 8'h00;
    return 8'(1 << m_pos);
  endfunction

  task automatic model_reset();
    m_running = 1'b0;
    m_pos     = -1;
    m_elapsed = 0;
    m_hist    = 3'b000;
    m_fs_prev = 2'b00;
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_edge();
    bit press;
    bit fs_chg;
    int period;
    // a level seen two edges ago that was low three edges ago is a new press
    press     = m_hist[1] & ~m_hist[2];
    fs_chg    = (freq_set != m_fs_prev);
    period    = 16 >> freq_set;
    m_hist    = {m_hist[1:0], button};
    m_fs_prev = freq_set;
    if (press) begin
      m_running = !m_running;
      if (m_running) begin
        m_elapsed = 0;
        if (m_pos < 0) m_pos = 0;
      end
    end else if (m_running) begin
      if (fs_chg) begin
        m_elapsed = 0;
      end else if (m_elapsed + 1 >= period) begin
        m_elapsed = 0;
        m_pos     = (m_pos + 1) % 8;
      end else begin
        m_elapsed++;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [7:0] exp;
    exp = model_led();
    checks++;
    assert (led === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, led, exp, $time);
    end
  endtask

  // Advance one clock, update the model, then sample 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
    check(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic pulse(input string tag);
    button = 1'b1;
    step(tag);
    button = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    rst      = 1'b0;
    button   = 1'b0;
    freq_set = 2'b01;

    // Reset held, then idle with no press: chaser stays dark.
    steps(2, "reset");
    rst = 1'b1;
    steps(50, "idle_dark");

    // First start at rate 01, run through a full wrap.
    pulse("start");
    steps(75, "run_div8");

    // Pause, hold for 100 cycles, resume.
    pulse("pause");
    steps(100, "paused");
    pulse("resume");
    steps(20, "resumed");

    // Rate changes while running.
    freq_set = 2'b10;
    steps(20, "rate_div4");
    freq_set = 2'b11;
    steps(20, "rate_div2");
    freq_set = 2'b01;

    // Run until 8'h20 is lit, then reset asynchronously mid-cycle.
    guard = 0;
    while (model_led() != 8'h20 && guard < 200) begin
      step("seek_20");
      guard++;
    end
    checks++;
    assert (guard < 200) else begin
      failures++;
      $error("FAIL seek_20_timeout observed=%0d expected<200", guard);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_reset");
    steps(2, "in_reset");
    rst = 1'b1;
    steps(3, "post_reset");
    pulse("restart");
    steps(20, "restarted");

    // Button held high: exactly one toggle, release does nothing.
    freq_set = 2'b11;
    button   = 1'b1;
    steps(20, "hold");
    button = 1'b0;
    steps(20, "release");

    // Randomised presses and rate changes against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) button = ~button;
      if ($urandom_range(0, 39) == 0) freq_set = 2'($urandom_range(0, 3));
      step("random");
    end
    button = 1'b0;
    steps(10, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flowing_water_lights.md
Name: flowing_water_lights

Overview:
- Eight-LED "flowing water" chaser: a single lit LED rotates left across led[7:0] at a rate chosen by freq_set.
- A push-button toggles between running and paused.
- Sits at board top level, between the user controls (button, 2-bit switch) and the LED bank.
- All timing derives from one system clock through an internal prescaler.

Parameters:
- DIV_00, default 16, clock cycles per LED step when freq_set=2'b00 (slowest).
- DIV_01, default 8, clock cycles per step when freq_set=2'b01.
- DIV_10, default 4, clock cycles per step when freq_set=2'b10.
- DIV_11, default 2, clock cycles per step when freq_set=2'b11 (fastest).
- CNT_W, default 24, prescaler counter width; must hold max(DIV_xx)-1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous and active-low (rst=0 resets); deassertion is synchronous to clk by the parent.
- button  input  1  start/pause request; asynchronous to clk and already debounced; active high.
- freq_set  input  2  step-rate select; quasi-static.
- led  output  8  LED drive, 1 = lit; registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - run=0, prescaler=0, button synchroniser/edge flops=0, freq_set capture=00.
  - led=8'h00.
- Button path:
  - Two-flop synchroniser (b_s1, b_s2), then a previous-value flop b_d.
  - press = b_s2 & ~b_d.
  - A button high at rising edge k makes press true in cycle k+1; run toggles at edge k+2.
  - Holding the button high gives exactly one press. Release generates nothing.
- Start (press while run=0):
  - run←1 and prescaler←0.
  - If led==8'h00 (first start after reset), led←8'h01. Otherwise led holds its value, so the chaser resumes from where it paused.
- Pause (press while run=1):
  - run←0 and led holds its current value.
  - The prescaler is frozen, and it is cleared on the next start.
- Prescaler, while run=1:
  - P = DIV selected by the current freq_set.
  - tick when cnt >= P-1; on a tick, cnt←0, otherwise cnt←cnt+1.
  - Because the compare is >=, lowering P mid-count never overruns.
- Step on tick: led←{led[6:0],led[7]}.
  - Wrap: 8'h80→8'h01.
  - Exactly one bit is set while running.
  - First step occurs P cycles after the start edge.
- freq_set change:
  - freq_set is registered each cycle (fs_q).
  - When freq_set != fs_q, cnt←0 that cycle and no tick occurs.
  - The new rate applies from the next full period; led is unchanged.
- Simultaneous press and tick: the press wins. Run toggles, no step occurs, cnt←0.
- Reset mid-operation: immediate return to led=8'h00 with run=0. The next press restarts from 8'h01.
- freq_set is sampled without a synchroniser. It is treated as quasi-static; glitches cost at most one period restart.

Test Plan:
- Reset with rst=0 for 2 cycles, then rst=1 and no press -> led=8'h00 held for 50 cycles.
- freq_set=01, 1-cycle button pulse -> led=8'h01 two edges after sampling; then 02,04,08… every 8 cycles, with 8'h80→8'h01 wrap after 8 steps.
- Second button pulse while running -> led freezes at its current value (e.g. 8'h08) for 100 cycles. A third pulse resumes with 8'h10 after 8 cycles.
- Change freq_set 01→10 while running -> counter restarts; the next step comes 4 cycles later, and steps then occur every 4 cycles. freq_set=11 gives steps every 2 cycles.
- Assert rst=0 mid-run at led=8'h20 -> led=8'h00 immediately (asynchronously). After release, a press restarts at 8'h01.
- Hold button high for 20 cycles -> exactly one toggle; the press coincident with a tick produces no step.
